dbus_dma: RTL and testbench
===========================

# dbus_dma

Single-channel block-copy DMA engine that acts as a second initiator on the data bus, alongside the CPU load/store port. It requests the bus from the core, copies `len` words from `src` to `dst`, then raises a one-cycle `done`. It targets the bus decoder's timing: read data arrives one cycle after the address, and writes commit in the same cycle as `we`. The CPU-side bus arbiter muxes this block's master port onto the decoder while `bus_gnt` is high.

## Interface
- `DW`, 16: data width; must match the data bus.
- `AW`, 16: address width; must match the data bus. The top 3 bits select the bus block.
- `LW`, 16: width of the transfer length and word counter.

- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `start` in 1: single-cycle request to begin a transfer; sampled only in IDLE.
- `src` in AW: source start address, latched on accepted `start`.
- `dst` in AW: destination start address, latched on accepted `start`.
- `len` in LW: word count, latched on accepted `start`.
- `fill` in 1: fill-mode select, latched on accepted `start`; ignored unless `DBUS_DMA_FILL_EN` is defined.
- `pattern` in DW: fill value, latched on accepted `start`.
- `bus_req` out 1: bus request to the arbiter.
- `bus_gnt` in 1: grant from the arbiter; may be withdrawn in any cycle.
- `m_addr` out AW: bus address.
- `m_din` out DW: bus write data (master to slave).
- `m_we` out 1: bus write enable, active-high.
- `m_dout` in DW: bus read data; valid one cycle after a read address.
- `busy` out 1: engine not in IDLE.
- `done` out 1: one-cycle pulse at the end of a transfer.

## Operation
- **States:** IDLE, REQ, RD, CAP, WR, DONE.
- **IDLE:**
  - On `start`, latch `src`/`dst`/`len`/`fill`/`pattern` into `sa`/`da`/`cnt`/`fm`/`pat`.
  - Go to REQ. If `len == 0`, go directly to DONE instead (no bus request).
- **REQ:** `bus_req` = 1. Stay until `bus_gnt` = 1. Then go to RD, or to WR if `fm` = 1.
- **RD:**
  - Drive `m_addr = sa`, `m_we` = 0.
  - If `bus_gnt` = 1, go to CAP. Otherwise hold in RD and re-issue the read once the grant returns.
- **CAP:**
  - Latch `m_dout` into `dq`. Drive `m_we` = 0 and `m_addr = sa`. Go to WR unconditionally.
  - Grant state is irrelevant here, because the read was issued under grant.
- **WR:**
  - Drive `m_addr = da`, `m_din = fm ? pat : dq`, `m_we = bus_gnt`.
  - If `bus_gnt` = 1:
    - `sa` <= `sa` + 1 and `da` <= `da` + 1, both modulo 2^AW (wrap FFFF to 0000).
    - `cnt` <= `cnt` − 1.
    - If `cnt == 1`, go to DONE. Otherwise go to RD, or stay in WR if `fm` = 1.
  - If `bus_gnt` = 0, hold.
- **DONE:** `done` = 1 and `bus_req` = 0 for one cycle, then go to IDLE.
- **`bus_req`:** 1 in REQ, RD, CAP and WR; 0 otherwise.
- **`m_we` safety:** `m_we` is never 1 outside WR, and never 1 while `bus_gnt` = 0.
- **Ignored starts:** `start` while `busy` is ignored and does not disturb the latched operands.
- **Overlap:** source and destination ranges may overlap. Copy order is always ascending, and no overlap correction is done.
- **Register use:** `m_din` holds `dq` outside WR. `m_addr` shows `sa` in IDLE, REQ and DONE.

## Timing
- **Reset values:** in the cycle after `rst`:
  - State = IDLE; `bus_req`, `m_we`, `busy`, `done` = 0.
  - `m_addr`, `m_din` = 0; all internal registers = 0.
- **Reset mid-transfer:** abandons the transfer, and no further write is issued. Words already written stay written.
- **Latency with `bus_gnt` held high, counted from the `start` sample edge in copy mode:**
  - 1 cycle REQ, then 3 cycles per word (RD, CAP, WR), then 1 cycle DONE.
  - `done` is high in cycle 3N+2 after the start edge.
  - `busy` is high for 3N+2 cycles.
- **Fill mode:** 1 cycle per word; `done` is high in cycle N+2.
- **`len = 0`:** `done` is high in cycle 1 after start and `busy` is high for 1 cycle. No bus activity.
- **Grant withdrawal:** each cycle with `bus_gnt` low in RD or WR adds exactly one cycle; counters do not move.
- **Read-data capture:** the 1-cycle read latency is absorbed by CAP. `m_dout` is sampled only at the end of CAP.

## Configuration
- **`DBUS_DMA_FILL_EN`:**
  - **Defined:** the `fill` input selects fill mode. `pattern` is written to `len` words at `dst`, with no reads and one word per granted cycle.
  - **Undefined:** `fm` is tied to 0. `fill` and `pattern` are unused, fill logic is not synthesised, and every transfer is a copy.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-transfer, with `len` = 8 and 3 words done. Require IDLE, all outputs 0, and only dst+0..dst+2 modified.
- **Basic copy:** RAM[0x0010..0x0013] = 1111, 2222, 3333, 4444; `start` with `src` = 0x0010, `dst` = 0x0040, `len` = 4, grant always high.
  - RAM[0x0040..0x0043] matches the source.
  - `done` pulses exactly in cycle 14.
  - `m_we` pulses in cycles 4, 7, 10, 13.
- **Grant loss:** as the basic copy, but with `bus_gnt` low for 2 cycles during the second RD and 3 cycles during the third WR. Require the same memory result, `done` in cycle 19, and `m_we` never high while `bus_gnt` is low.
- **Boundaries:**
  - `len` = 0: `done` in cycle 1 and `bus_req` never high.
  - `src` = 0xFFFE, `len` = 3: reads at FFFE, FFFF, 0000.
  - `start` pulsed again mid-transfer: ignored.
- **Fill (with macro):** `fill` = 1, `pattern` = 0xA5A5, `dst` = 0x0020, `len` = 5. Require RAM[0x20..0x24] = A5A5, no reads issued, and `done` in cycle 7.
- **Fill (without macro):** the same stimulus performs a copy from `src`, and `done` is in cycle 17.

Source files
------------

// File: rtl/dbus_dma.sv
// Single-channel block-copy DMA acting as a second data-bus initiator.
// Optional fill mode is compiled in when DBUS_DMA_FILL_EN is defined.
module dbus_dma #(
    parameter int DW = 16,
    parameter int AW = 16,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    input  logic          fill_i,
    input  logic [DW-1:0] pattern_i,
    output logic          bus_req_o,
    input  logic          bus_gnt_i,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_din_o,
    output logic          m_we_o,
    input  logic [DW-1:0] m_dout_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [2:0]    state_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] sa_q, sa_d;
    logic [AW-1:0] da_q, da_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dq_q, dq_d;
    logic          fm;
    logic [DW-1:0] wr_data;

    wire accept = (state_q == S_IDLE) && start_i;

`ifdef DBUS_DMA_FILL_EN
    logic          fm_q, fm_d;
    logic [DW-1:0] pat_q, pat_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fm_q  <= 1'b0;
            pat_q <= '0;
        end else begin
            fm_q  <= fm_d;
            pat_q <= pat_d;
        end
    end

    always_comb begin
        fm_d  = fm_q;
        pat_d = pat_q;
        if (accept) begin
            fm_d  = fill_i;
            pat_d = pattern_i;
        end
    end

    assign fm      = fm_q;
    assign wr_data = fm_q ? pat_q : dq_q;
`else
    logic unused_fill;
    assign unused_fill = &{1'b0, fill_i, pattern_i};
    assign fm          = 1'b0;
    assign wr_data     = dq_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            da_q    <= '0;
            cnt_q   <= '0;
            dq_q    <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            da_q    <= da_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        da_d    = da_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sa_d    = src_i;
                    da_d    = dst_i;
                    cnt_d   = len_i;
                    state_d = (len_i == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_gnt_i) state_d = fm ? S_WR : S_RD;
            end
            S_RD: begin
                // An ungranted read is simply re-issued on the next cycle.
                if (bus_gnt_i) state_d = S_CAP;
            end
            S_CAP: begin
                dq_d    = m_dout_i;
                state_d = S_WR;
            end
            S_WR: begin
                if (bus_gnt_i) begin
                    sa_d  = sa_q + AW'(1);
                    da_d  = da_q + AW'(1);
                    cnt_d = cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) state_d = S_DONE;
                    else                 state_d = fm ? S_WR : S_RD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus_req_o = (state_q == S_REQ) || (state_q == S_RD) ||
                       (state_q == S_CAP) || (state_q == S_WR);
    assign m_we_o    = (state_q == S_WR) && bus_gnt_i;
    assign m_addr_o  = (state_q == S_WR) ? da_q : sa_q;
    assign m_din_o   = (state_q == S_WR) ? wr_data : dq_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign state_o   = state_q;

endmodule

// File: tb/tb_dbus_dma.sv
// Table-driven bench for dbus_dma: a 64K-word memory behind the master port,
// a transfer table with hand-computed completion cycles, and a reset sequence.
module tb_dbus_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [15:0] src_i, dst_i, len_i;
  logic        fill_i;
  logic [15:0] pattern_i;
  logic        bus_req_o;
  logic        bus_gnt_i;
  logic [15:0] m_addr_o, m_din_o, m_dout_i;
  logic        m_we_o, busy_o, done_o;
  logic [2:0]  state_o;

`ifdef DBUS_DMA_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam logic [2:0] ST_RD = 3'd2;

  dbus_dma #(.DW(16), .AW(16), .LW(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_i(src_i), .dst_i(dst_i),
    .len_i(len_i), .fill_i(fill_i), .pattern_i(pattern_i),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .m_addr_o(m_addr_o),
    .m_din_o(m_din_o), .m_we_o(m_we_o), .m_dout_i(m_dout_i),
    .busy_o(busy_o), .done_o(done_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  // memory: read data one cycle after the address, writes commit on the edge
  logic [15:0] mem [0:65535];
  logic [15:0] model [0:65535];
  logic [15:0] rdata;
  assign m_dout_i = rdata;
  always @(posedge clk) begin
    if (m_we_o) mem[m_addr_o] <= m_din_o;
    rdata <= mem[m_addr_o];
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    case (a)
      16'h0010: return 16'h1111;
      16'h0011: return 16'h2222;
      16'h0012: return 16'h3333;
      16'h0013: return 16'h4444;
      default:  return 16'(a) ^ 16'hC3C3;
    endcase
  endfunction

  task automatic init_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i]   = init_val(i);
      model[i] = init_val(i);
    end
  endtask

  typedef struct {
    logic [15:0] src;
    logic [15:0] dst;
    logic [15:0] len;
    logic        fill;
    logic [15:0] pat;
    int          l1s, l1n, l2s, l2n;  // grant-low windows (cycle, length)
    int          rs;                  // cycle of a stray start pulse, 0 = none
    int          done_fill;
    int          done_copy;
  } vec_t;

  vec_t tbl [7];

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] exp_a_q[$];

  task automatic run_vec(input int v);
    vec_t t;
    bit fe;
    int exp_done, done_cyc, busy_cnt, nwr, we_nogrant, bad_rd;
    bit saw_req, low;
    int we_cyc[$];
    logic [15:0] rd_q[$];
    logic [15:0] a, d;
    int exp_we[4];
    t = tbl[v];
    fe = FILL_EN && t.fill;
    exp_we = '{4, 7, 10, 13};
    init_mem();
    exp_q.delete();
    exp_a_q.delete();
    for (int i = 0; i < int'(t.len); i++) begin
      a = t.src + 16'(i);
      d = fe ? t.pat : model[a];
      model[16'(t.dst + 16'(i))] = d;
      exp_q.push_back(d);
      exp_a_q.push_back(t.dst + 16'(i));
    end
    exp_done = fe ? t.done_fill : t.done_copy;
    done_cyc = 0; busy_cnt = 0; nwr = 0; we_nogrant = 0; saw_req = 0;

    src_i = t.src; dst_i = t.dst; len_i = t.len;
    fill_i = t.fill; pattern_i = t.pat; bus_gnt_i = 1'b1;
    start_i = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= exp_done + 3; cyc++) begin
      if (cyc == t.rs) begin
        start_i = 1'b1; src_i = 16'h0300; dst_i = 16'h0060; len_i = 16'd2;
      end else begin
        start_i = 1'b0;
      end
      low = (cyc >= t.l1s && cyc < t.l1s + t.l1n) ||
            (cyc >= t.l2s && cyc < t.l2s + t.l2n);
      bus_gnt_i = !low;
      @(negedge clk);
      if (done_o && done_cyc == 0) done_cyc = cyc;
      if (busy_o) busy_cnt++;
      if (bus_req_o) saw_req = 1'b1;
      if (m_we_o && !bus_gnt_i) we_nogrant++;
      if (state_o == ST_RD && bus_gnt_i) rd_q.push_back(m_addr_o);
      if (m_we_o) begin
        nwr++;
        we_cyc.push_back(cyc);
        if (exp_q.size() > 0) begin
          check("wr_addr", m_addr_o, exp_a_q.pop_front());
          check("wr_data", m_din_o, exp_q.pop_front());
        end
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    bus_gnt_i = 1'b1;

    check("done_cycle", done_cyc, exp_done);
    check("busy_cycles", busy_cnt, exp_done);
    check("we_without_gnt", we_nogrant, 0);
    check("bus_req_seen", saw_req, t.len != 0);
    check("write_count", nwr, t.len);
    check("read_count", rd_q.size(), fe ? 0 : int'(t.len));
    bad_rd = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== 16'(t.src + 16'(i))) bad_rd++;
    check("read_addr", bad_rd, 0);
    bad_rd = 0;
    for (int i = 0; i < 65536; i++)
      if (mem[i] !== model[i]) bad_rd++;
    check("mem_image", bad_rd, 0);
    if (v == 0) begin
      for (int i = 0; i < 4; i++)
        check("we_cycle", (i < we_cyc.size()) ? we_cyc[i] : -1, exp_we[i]);
    end
  endtask

  initial begin
    // src, dst, len, fill, pat, l1s, l1n, l2s, l2n, rs, done_fill, done_copy
    tbl[0] = '{16'h0010, 16'h0040, 16'd4, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 14, 14};
    tbl[1] = '{16'h0010, 16'h0040, 16'd4, 1'b0, 16'h0000, 5, 2, 12, 3, 0, 19, 19};
    tbl[2] = '{16'h0010, 16'h0040, 16'd0, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 1, 1};
    tbl[3] = '{16'hFFFE, 16'h0080, 16'd3, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 11, 11};
    tbl[4] = '{16'h0010, 16'h0050, 16'd4, 1'b0, 16'h0000, 0, 0, 0, 0, 6, 14, 14};
    tbl[5] = '{16'h0010, 16'h0020, 16'd5, 1'b1, 16'hA5A5, 0, 0, 0, 0, 0, 7, 17};
    tbl[6] = '{16'h0010, 16'h0011, 16'd3, 1'b0, 16'h0000, 0, 0, 0, 0, 0, 11, 11};

    rst = 1'b1; start_i = 1'b0; src_i = '0; dst_i = '0; len_i = '0;
    fill_i = 1'b0; pattern_i = '0; bus_gnt_i = 1'b0;
    init_mem();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", state_o, 3'd0);
    check("rst_bus_req", bus_req_o, 1'b0);
    check("rst_m_we", m_we_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_m_addr", m_addr_o, 16'h0000);
    check("rst_m_din", m_din_o, 16'h0000);
    @(posedge clk); #1;

    for (int v = 0; v < 7; v++) run_vec(v);

    // reset after three of eight words have been written
    init_mem();
    src_i = 16'h0100; dst_i = 16'h0200; len_i = 16'd8; fill_i = 1'b0;
    bus_gnt_i = 1'b1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state", state_o, 3'd0);
    check("mid_rst_outputs", {bus_req_o, m_we_o, busy_o, done_o}, 4'b0000);
    check("mid_rst_m_addr", m_addr_o, 16'h0000);
    check("mid_rst_m_din", m_din_o, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      check("mid_rst_mem", mem[16'h0200 + i],
            (i < 3) ? init_val(16'h0100 + i) : init_val(16'h0200 + i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
